voice_alloc: RTL and testbench
==============================

# voice_alloc

Polyphonic voice allocator that sits between the key-event source and a bank of NUM_VOICES note synthesizer instances. It accepts note-on/note-off events over a valid/ready handshake and drives each voice's 8-bit note ID. A note ID of 0 silences a voice. When every voice is busy, the allocator steals the oldest one. Allocation is a sequential scan over the voice table, one voice per cycle.

## Interface
- NUM_VOICES, 4: number of voice slots; must be 2..16; index width is $clog2(NUM_VOICES).
- AGE_W, 8: width of each voice's saturating age counter.
- clk  in  1  system clock; everything is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- all_off  in  1  panic; silences every voice; sampled every cycle.
- ev_valid  in  1  event offered.
- ev_ready  out  1  allocator can accept; high only when state is IDLE and rst is low.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_noteid  in  8  note ID; 0 is not a valid note.
- voice_noteid  out  8*NUM_VOICES  note ID of voice i at bits [8i+7:8i]; 0 = silent.
- voice_active  out  NUM_VOICES  bit i set while voice i holds a note.
- steal_pulse  out  1  one-cycle pulse when a note-on evicted a sounding voice.

## Operation
- Per-voice state: noteid (8 bits), active (1 bit), age (AGE_W bits). Registered outputs are driven directly from this state.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - ev_ready=1. On ev_valid&&ev_ready, latch ev_on and ev_noteid, set idx=0, clear the match/free/oldest trackers, and go to SCAN.
  - If an accepted ev_noteid==0, the event is consumed and dropped; the FSM stays in IDLE.
- SCAN: examine voice idx in each cycle.
  - Match: the first active voice whose noteid equals the latched note.
  - Free: the lowest-index voice that is not active.
  - Oldest: the active voice with the largest age; a strict > comparison, so ties go to the lowest index.
  - After idx==NUM_VOICES-1, go to COMMIT.
- COMMIT (one cycle), then return to IDLE.
  - Note-on with a match: the matched voice's noteid is unchanged (no re-articulation). Its age goes to 0. Every other active voice's age increments, saturating at 2^AGE_W-1.
  - Note-on, no match, a free voice exists: that voice gets noteid=note, active=1, age=0. Other active voices' ages increment (saturating).
  - Note-on, no match, no free voice: the oldest voice is overwritten with noteid=note and age=0. Other active voices' ages increment. steal_pulse=1.
  - Note-off with a match: that voice gets noteid=0, active=0, age=0. Other voices are unchanged.
  - Note-off without a match: no change.
- all_off (when rst is low): in any state, all voices get noteid=0, active=0, age=0. The FSM goes to IDLE and any latched event is discarded. all_off takes priority over COMMIT in the same cycle.
- rst: same as all_off, and steal_pulse is cleared. rst has the highest priority, including mid-SCAN or mid-COMMIT.

## Timing
- Reset values: voice_noteid=0, voice_active=0, steal_pulse=0, ev_ready=0 while rst=1. ev_ready=1 in the first cycle after rst is deasserted.
- Let E0 be the accepting edge. Edges E1..EN evaluate voices 0..N-1. Edge E(N+1) commits.
- voice_noteid, voice_active and steal_pulse take their new values after E(N+1). steal_pulse falls after E(N+2).
- ev_ready is low for N+1 cycles after E0. The earliest next accept is at E(N+2), giving a throughput of one event per N+2 cycles.
- ev_noteid and ev_on may change after E0; only the latched copies are used.
- Outputs never glitch mid-scan. Voice state changes only at a COMMIT edge or on all_off/rst.
- An all_off/rst asserted on edge Ek takes effect at Ek. ev_ready is high in the following cycle (provided rst is low).

## Test plan
- Reset: assert rst for 3 cycles with ev_valid=1 -> no accept, all outputs 0. After rst falls, ev_ready=1 the next cycle.
- Single note-on, N=4: on 60 -> ev_ready low for 5 cycles; after E5, voice_noteid[7:0]=60, voice_active=4'b0001, steal_pulse stays 0.
- Fill and steal: on 60, 62, 64, 65 -> voices 0..3, ages 3,2,1,0. Then on 67 -> voice0=67, steal_pulse high for exactly one cycle, ages become 0,3,2,1.
- Match refresh then steal: continuing, on 62 -> no noteid change, ages 1,0,3,2. Then on 69 -> voice2 (was 64) becomes 69 with steal_pulse.
- Release and reuse:
  - off 62 -> voice1=0, voice_active bit1 clear.
  - off 50 (not sounding) -> no change.
  - on 71 -> voice1=71 (lowest free), no steal_pulse.
  - on with noteid 0 -> accepted, dropped, ev_ready high the next cycle.
- Abort: accept on 72, then assert all_off at E2 (mid-SCAN) -> all voices 0, voice_active=0, 72 never appears, ev_ready high the next cycle. Repeat with rst at E5 (the COMMIT edge) -> same result, and steal_pulse stays 0.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: a sequential scan over the voice table picks a
// matching, free or oldest voice for each key event, then commits in one cycle.
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      all_off,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic                      ev_on,
  input  logic [7:0]                ev_noteid,
  output logic [8*NUM_VOICES-1:0]   voice_noteid,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic                      steal_pulse,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  // Handshake: an event transfers on a clk edge where ev_valid && ev_ready.
  // ev_ready is high only in IDLE with rst low; ev_on/ev_noteid are latched
  // at that edge and may change freely afterwards.

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             on_q, on_d;
  logic [7:0]       note_q, note_d;
  logic             match_found_q, match_found_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_found_q, free_found_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             old_found_q, old_found_d;
  logic [IDX_W-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic             steal_q, steal_d;

  logic [7:0]            noteid_q [NUM_VOICES];
  logic [7:0]            noteid_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];
  logic [IDX_W-1:0]      tgt;

  assign ev_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    on_d          = on_q;
    note_d        = note_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    steal_d       = 1'b0;
    noteid_d      = noteid_q;
    active_d      = active_q;
    age_d         = age_q;
    tgt           = '0;

    case (state_q)
      IDLE: begin
        // A note ID of 0 is consumed without starting a scan.
        if (ev_valid && ev_ready && ev_noteid != 8'd0) begin
          on_d          = ev_on;
          note_d        = ev_noteid;
          idx_d         = '0;
          match_found_d = 1'b0;
          match_idx_d   = '0;
          free_found_d  = 1'b0;
          free_idx_d    = '0;
          old_found_d   = 1'b0;
          old_idx_d     = '0;
          old_age_d     = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (active_q[idx_q] && noteid_q[idx_q] == note_q && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!active_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict > keeps the lowest index on equal ages.
        if (active_q[idx_q] && (!old_found_q || age_q[idx_q] > old_age_q)) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = age_q[idx_q];
        end
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
        if (on_q) begin
          if (match_found_q)     tgt = match_idx_q;
          else if (free_found_q) tgt = free_idx_q;
          else begin
            tgt     = old_idx_q;
            steal_d = 1'b1;
          end
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt) begin
              noteid_d[i] = note_q;
              active_d[i] = 1'b1;
              age_d[i]    = '0;
            end else if (active_q[i] && age_q[i] != AGE_MAX) begin
              age_d[i] = age_q[i] + 1'b1;
            end
          end
        end else if (match_found_q) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == match_idx_q) begin
              noteid_d[i] = 8'd0;
              active_d[i] = 1'b0;
              age_d[i]    = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Panic overrides any commit in the same cycle.
    if (all_off) begin
      state_d  = IDLE;
      steal_d  = 1'b0;
      active_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        noteid_d[i] = 8'd0;
        age_d[i]    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      on_q          <= 1'b0;
      note_q        <= 8'd0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      steal_q       <= 1'b0;
      active_q      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        noteid_q[i] <= 8'd0;
        age_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      on_q          <= on_d;
      note_q        <= note_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      steal_q       <= steal_d;
      active_q      <= active_d;
      noteid_q      <= noteid_d;
      age_q         <= age_d;
    end
  end

  always_comb begin
    voice_noteid = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_noteid[8*i +: 8] = noteid_q[i];
  end

  assign voice_active = active_q;
  assign steal_pulse  = steal_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: each event pushes its expected voice table
// into a queue; a monitor pops and compares whenever ev_ready rises again.
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic        all_off;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [7:0]  ev_noteid;
  logic [31:0] voice_noteid;
  logic [3:0]  voice_active;
  logic        steal_pulse;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Packed expectation: {voice_noteid[31:0], voice_active[3:0], steal_pulse}
  logic [36:0] exp_q[$];

  voice_alloc #(.NUM_VOICES(4), .AGE_W(8)) dut (
    .clk(clk), .rst(rst), .all_off(all_off),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_noteid(ev_noteid),
    .voice_noteid(voice_noteid), .voice_active(voice_active),
    .steal_pulse(steal_pulse), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a rising ev_ready marks the end of a commit, abort or reset.
  logic rdy_prev = 1'b0;
  logic fall_chk = 1'b0;
  always @(negedge clk) begin
    logic [36:0] e;
    if (fall_chk) begin
      check("steal_fall", steal_pulse, 0);
      fall_chk = 1'b0;
    end
    if (ev_ready === 1'b1 && rdy_prev !== 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("voice_noteid", voice_noteid, e[36:5]);
        check("voice_active", voice_active, e[4:1]);
        check("steal_pulse", steal_pulse, e[0]);
        fall_chk = 1'b1;
      end
    end
    rdy_prev = ev_ready;
  end

  task automatic wait_ready();
    int n = 0;
    while (ev_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ev_ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic on, input logic [7:0] note,
                      input logic [31:0] enid, input logic [3:0] eact, input logic est);
    int n;
    wait_ready();
    ev_valid  = 1'b1;
    ev_on     = on;
    ev_noteid = note;
    if (note != 8'd0) exp_q.push_back({enid, eact, est});
    @(posedge clk);
    #1;
    ev_valid  = 1'b0;
    ev_on     = ~on;
    ev_noteid = 8'hAA;
    @(negedge clk);
    n = 0;
    while (ev_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, (note != 8'd0) ? 5 : 0);
  endtask

  // Accept note-on 72, then pulse all_off (use_rst=0) or rst at edge E<at_edge>.
  task automatic abort_run(input logic use_rst, input int at_edge);
    wait_ready();
    ev_valid  = 1'b1;
    ev_on     = 1'b1;
    ev_noteid = 8'd72;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    ev_valid  = 1'b0;
    ev_noteid = 8'hAA;
    repeat (at_edge - 1) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else         all_off = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    all_off = 1'b0;
    @(negedge clk);
    check("abort_ready", ev_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    all_off   = 1'b0;
    ev_valid  = 1'b1;
    ev_on     = 1'b1;
    ev_noteid = 8'd99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ev_ready, 0);
    check("rst_noteid", voice_noteid, 0);
    check("rst_active", voice_active, 0);
    check("rst_steal", steal_pulse, 0);
    check("rst_state", dbg_state, 0);
    ev_valid = 1'b0;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    send(1, 8'd60, 32'h0000003C, 4'b0001, 0);
    send(1, 8'd62, 32'h00003E3C, 4'b0011, 0);
    send(1, 8'd64, 32'h00403E3C, 4'b0111, 0);
    send(1, 8'd65, 32'h41403E3C, 4'b1111, 0);
    send(1, 8'd67, 32'h41403E43, 4'b1111, 1);
    send(1, 8'd62, 32'h41403E43, 4'b1111, 0);
    send(1, 8'd69, 32'h41453E43, 4'b1111, 1);
    send(0, 8'd62, 32'h41450043, 4'b1101, 0);
    send(0, 8'd50, 32'h41450043, 4'b1101, 0);
    send(1, 8'd71, 32'h41454743, 4'b1111, 0);
    send(1, 8'd0,  32'h41454743, 4'b1111, 0);
    check("drop_noteid", voice_noteid, 32'h41454743);
    check("drop_active", voice_active, 4'b1111);
    send(1, 8'd73, 32'h49454743, 4'b1111, 1);

    abort_run(1'b0, 2);

    send(1, 8'd60, 32'h0000003C, 4'b0001, 0);
    send(1, 8'd62, 32'h00003E3C, 4'b0011, 0);
    send(1, 8'd64, 32'h00403E3C, 4'b0111, 0);
    send(1, 8'd65, 32'h41403E3C, 4'b1111, 0);
    abort_run(1'b1, 5);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
